// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave exposing a small bank of 32-bit read/write registers.
// Write address and data are buffered independently; reads return one cycle after AR.
module axi4lite_slave_regs #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 5,
    parameter int C_NUM_REGS   = 4
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    input  logic [C_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic [C_DATA_WIDTH*C_NUM_REGS-1:0] regs_o
);

    localparam int IDX_W   = C_ADDR_WIDTH - 2;
    localparam int N_SLOTS = 1 << IDX_W;
    localparam int STRB_W  = C_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [C_DATA_WIDTH-1:0] merge_bytes(
        input logic [C_DATA_WIDTH-1:0] old_val,
        input logic [C_DATA_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]       strb
    );
        logic [C_DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return ({{(32-IDX_W){1'b0}}, idx} < 32'(C_NUM_REGS));
    endfunction

    logic                    ready_en_r;
    logic                    aw_full_r;
    logic                    w_full_r;
    logic [IDX_W-1:0]        aw_idx_r;
    logic [C_DATA_WIDTH-1:0] w_data_r;
    logic [STRB_W-1:0]       w_strb_r;
    logic                    bvalid_r;
    logic [1:0]              bresp_r;
    logic                    rvalid_r;
    logic [1:0]              rresp_r;
    logic [C_DATA_WIDTH-1:0] rdata_r;
    logic [C_DATA_WIDTH-1:0] regs_r [N_SLOTS];

    logic                    aw_hs_s;
    logic                    w_hs_s;
    logic                    ar_hs_s;
    logic                    commit_s;
    logic [IDX_W-1:0]        ar_idx_s;
    logic                    unused_s;

    // ready_en_r keeps every READY low through reset and its first edge after release
    assign S_AXI_AWREADY = ready_en_r && !aw_full_r;
    assign S_AXI_WREADY  = ready_en_r && !w_full_r;
    assign S_AXI_ARREADY = ready_en_r && (!rvalid_r || S_AXI_RREADY);
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_RDATA   = rdata_r;

    assign aw_hs_s  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs_s   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs_s  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit_s = aw_full_r && w_full_r && (!bvalid_r || S_AXI_BREADY);
    assign ar_idx_s = S_AXI_ARADDR[C_ADDR_WIDTH-1:2];
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write channel buffers, ready enable and write response
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ready_en_r <= 1'b0;
            aw_full_r  <= 1'b0;
            w_full_r   <= 1'b0;
            aw_idx_r   <= {IDX_W{1'b0}};
            w_data_r   <= {C_DATA_WIDTH{1'b0}};
            w_strb_r   <= {STRB_W{1'b0}};
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
        end else begin
            ready_en_r <= 1'b1;
            if (commit_s) begin
                aw_full_r <= 1'b0;
                w_full_r  <= 1'b0;
                bvalid_r  <= 1'b1;
                bresp_r   <= in_range(aw_idx_r) ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs_s) begin
                    aw_full_r <= 1'b1;
                    aw_idx_r  <= S_AXI_AWADDR[C_ADDR_WIDTH-1:2];
                end
                if (w_hs_s) begin
                    w_full_r <= 1'b1;
                    w_data_r <= S_AXI_WDATA;
                    w_strb_r <= S_AXI_WSTRB;
                end
                if (S_AXI_BREADY) begin
                    bvalid_r <= 1'b0;
                end
            end
        end
    end

    // Register bank; only the first C_NUM_REGS slots are ever written
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int k = 0; k < N_SLOTS; k++) begin
                regs_r[k] <= {C_DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < N_SLOTS; k++) begin
                if (commit_s && (aw_idx_r == IDX_W'(k)) && (k < C_NUM_REGS)) begin
                    regs_r[k] <= merge_bytes(regs_r[k], w_data_r, w_strb_r);
                end
            end
        end
    end

    // Read channel; regs_r is sampled before any same-edge commit lands
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_r <= 1'b0;
            rresp_r  <= RESP_OKAY;
            rdata_r  <= {C_DATA_WIDTH{1'b0}};
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            if (in_range(ar_idx_s)) begin
                rdata_r <= regs_r[ar_idx_s];
                rresp_r <= RESP_OKAY;
            end else begin
                rdata_r <= {C_DATA_WIDTH{1'b0}};
                rresp_r <= RESP_SLVERR;
            end
        end else if (S_AXI_RREADY) begin
            rvalid_r <= 1'b0;
        end
    end

    // Flatten the implemented registers onto regs_o
    always_comb begin
        regs_o = {(C_DATA_WIDTH*C_NUM_REGS){1'b0}};
        for (int k = 0; k < C_NUM_REGS; k++) begin
            regs_o[C_DATA_WIDTH*k +: C_DATA_WIDTH] = regs_r[k];
        end
    end

endmodule

// File: doc/axi4lite_slave_regs.md
AXI4LITE_SLAVE_REGS -- requirements
Module: axi4lite_slave_regs

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 32, giving the data bus and register width; only 32 is supported.
REQ-002 SHALL have parameter C_ADDR_WIDTH, default 5, giving the byte address width (8 word slots).
REQ-003 SHALL have parameter C_NUM_REGS, default 4, giving the number of implemented registers (word slots 0..C_NUM_REGS-1).
REQ-004 SHALL have port ACLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port ARESETN, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports S_AXI_AWADDR in [C_ADDR_WIDTH], S_AXI_AWPROT in [3], S_AXI_AWVALID in [1] and S_AXI_AWREADY out [1]: the write address channel.
REQ-007 SHALL have ports S_AXI_WDATA in [32], S_AXI_WSTRB in [4], S_AXI_WVALID in [1] and S_AXI_WREADY out [1]: the write data channel.
REQ-008 SHALL have ports S_AXI_BRESP out [2], S_AXI_BVALID out [1] and S_AXI_BREADY in [1]: the write response channel.
REQ-009 SHALL have ports S_AXI_ARADDR in [C_ADDR_WIDTH], S_AXI_ARPROT in [3], S_AXI_ARVALID in [1] and S_AXI_ARREADY out [1]: the read address channel.
REQ-010 SHALL have ports S_AXI_RDATA out [32], S_AXI_RRESP out [2], S_AXI_RVALID out [1] and S_AXI_RREADY in [1]: the read data channel.
REQ-011 SHALL have port regs_o, output, [32*C_NUM_REGS]: current register contents, with reg k at bits [32k+31:32k].

Function
REQ-012 SHALL decode the word index as ADDR[C_ADDR_WIDTH-1:2] and ignore ADDR[1:0]; PROT inputs are ignored.
REQ-013 SHALL hold separate AW and W buffers, each holding one entry, each with a full flag.
REQ-014 SHALL drive AWREADY = !aw_full and WREADY = !w_full, decoded from registered state only; there is no VALID->READY combinational path.
REQ-015 SHALL accept AW and W independently and in either order, including in the same cycle; an AW or W handshake loads its buffer and sets its full flag.
REQ-016 SHALL commit a write on the edge where aw_full && w_full && (!BVALID || BREADY).
REQ-017 On commit SHALL update the addressed register byte-wise per WSTRB, set BVALID, load BRESP, and clear both full flags.
REQ-018 SHALL set BRESP = 2'b00 (OKAY) when index < C_NUM_REGS; otherwise BRESP = 2'b10 (SLVERR) and no register changes.
REQ-019 SHALL give a minimum write latency of 1 cycle: AW and W handshake at edge N, commit at edge N+1, BVALID high after edge N+1.
REQ-020 SHALL hold BVALID and BRESP stable until the BVALID && BREADY handshake, then drop BVALID unless a new commit occurs on the same edge.
REQ-021 SHALL stall writes while BVALID is high and BREADY is low: the full buffers hold, and AWREADY and WREADY stay low.
REQ-022 SHALL drive ARREADY = !RVALID || RREADY.
REQ-023 On an AR handshake SHALL register RDATA from the addressed register's value before this edge and set RVALID.
REQ-024 SHALL return RDATA = 0 and RRESP = 2'b10 for an out-of-range read index; otherwise RRESP = 2'b00.
REQ-025 SHALL give a read latency of 1 cycle: RVALID is high after the AR handshake edge.
REQ-026 SHALL hold RDATA, RRESP and RVALID stable until the R handshake.
REQ-027 SHALL allow back-to-back reads at 1 per cycle when RREADY is held high.
REQ-028 SHALL run the read and write paths concurrently.
REQ-029 On a read and a commit to the same register on the same edge, SHALL return the pre-write value on R.
REQ-030 SHALL make regs_o reflect a commit in the cycle after the commit edge.

Reset
REQ-031 While ARESETN is low SHALL force all registers to 0, aw_full = w_full = 0, BVALID = RVALID = 0, BRESP = RRESP = 0 and RDATA = 0.
REQ-032 While ARESETN is low SHALL drive AWREADY, WREADY and ARREADY low.
REQ-033 SHALL raise AWREADY, WREADY and ARREADY on the first rising edge after ARESETN deasserts.
REQ-034 On reset mid-transaction SHALL discard all buffered AW/W entries and pending responses; no partial register update is permitted.

Verification
REQ-035 Sequential write/read: write 1, 2, 3, 4 to 0x0, 0x4, 0x8, 0xC with WSTRB = 4'hF, then read the same addresses -> each BRESP = OKAY, RDATA = 1, 2, 3, 4 in order, RRESP = OKAY, and regs_o = {4, 3, 2, 1}.
REQ-036 Byte strobes: reg1 holds 0x11223344; write 0xAABBCCDD to 0x4 with WSTRB = 4'b0101 -> reading 0x4 returns 0x11BB33DD.
REQ-037 Channel order and backpressure: W presented 3 cycles before AW, with BREADY low for 5 cycles -> commit occurs 1 cycle after AW is accepted; BVALID and BRESP stay stable; a second AW/W is accepted into the buffers but not committed until the B handshake.
REQ-038 Out of range: write 0xFFFFFFFF to 0x10 -> BRESP = SLVERR and regs_o is unchanged; reading 0x14 -> RDATA = 0, RRESP = SLVERR.
REQ-039 Collision: AR to 0x8 and a commit to 0x8 on the same edge, with reg2 = 2 and new data 0x55 -> RDATA = 2; the next read of 0x8 -> 0x55.
REQ-040 Reset mid-op: assert ARESETN low while aw_full = 1 and BVALID = 1 -> all outputs at reset values; after release, reading 0x0 returns 0 and no stale BVALID appears.
